// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, funcs, ALU/PC codes, FSM states.
// The TRAP state exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  typedef enum logic [2:0] {
    ST_START, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       sext;
    logic       regrt;
    logic       alium;
    logic       shift;
    logic [3:0] aluc;
    logic       is_j;
    logic       is_jal;
    logic       is_jr;
    logic       is_br;
    logic       is_bne;
    logic       is_lw;
    logic       is_sw;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Static decode of op/func into datapath controls, instruction class and an illegal flag.
// Purely combinational; no handshake.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int FUNC_W = 6
) (
  input  logic [OP_W-1:0]            op,
  input  logic [FUNC_W-1:0]          func,
  output logic [$bits(ctrl_t)-1:0]   ctl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (op)
      OP_W'(OP_RTYPE): begin
        case (func)
          FUNC_W'(FN_ADD): c.aluc = ALU_ADD;
          FUNC_W'(FN_SUB): c.aluc = ALU_SUB;
          FUNC_W'(FN_AND): c.aluc = ALU_AND;
          FUNC_W'(FN_OR):  c.aluc = ALU_OR;
          FUNC_W'(FN_XOR): c.aluc = ALU_XOR;
          FUNC_W'(FN_SLL): begin c.shift = 1'b1; c.aluc = ALU_SLL; end
          FUNC_W'(FN_SRL): begin c.shift = 1'b1; c.aluc = ALU_SRL; end
          FUNC_W'(FN_SRA): begin c.shift = 1'b1; c.aluc = ALU_SRA; end
          FUNC_W'(FN_JR):  c.is_jr = 1'b1;
          default:         c.illegal = 1'b1;
        endcase
      end
      OP_W'(OP_ADDI): begin c.sext = 1'b1; c.regrt = 1'b1; c.alium = 1'b1; c.aluc = ALU_ADD; end
      OP_W'(OP_ANDI): begin c.regrt = 1'b1; c.alium = 1'b1; c.aluc = ALU_AND; end
      OP_W'(OP_ORI):  begin c.regrt = 1'b1; c.alium = 1'b1; c.aluc = ALU_OR; end
      OP_W'(OP_XORI): begin c.regrt = 1'b1; c.alium = 1'b1; c.aluc = ALU_XOR; end
      OP_W'(OP_LUI):  begin c.regrt = 1'b1; c.alium = 1'b1; c.aluc = ALU_LUI; end
      OP_W'(OP_LW):   begin c.sext = 1'b1; c.regrt = 1'b1; c.alium = 1'b1; c.aluc = ALU_ADD; c.is_lw = 1'b1; end
      OP_W'(OP_SW):   begin c.sext = 1'b1; c.alium = 1'b1; c.aluc = ALU_ADD; c.is_sw = 1'b1; end
      OP_W'(OP_BEQ):  begin c.sext = 1'b1; c.aluc = ALU_SUB; c.is_br = 1'b1; end
      OP_W'(OP_BNE):  begin c.sext = 1'b1; c.aluc = ALU_SUB; c.is_br = 1'b1; c.is_bne = 1'b1; end
      OP_W'(OP_J):    c.is_j = 1'b1;
      OP_W'(OP_JAL):  begin c.is_j = 1'b1; c.is_jal = 1'b1; end
      default:        c.illegal = 1'b1;
    endcase
  end

  assign ctl = c;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: START/FETCH/DECODE/EXEC/MEM/WB with a mem_ready watchdog.
// Outputs are combinational from state; memory waits stall on mem_ready. MC_CTRL_ILLEGAL_TRAP_EN adds TRAP.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNC_W  = 6,
  parameter int ALUC_W  = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  input  logic              z,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              pcwrite,
  output logic              irwrite,
  output logic              sext,
  output logic              regrt,
  output logic              jal,
  output logic              wreg,
  output logic              alium,
  output logic              shift,
  output logic              m2reg,
  output logic [ALUC_W-1:0] aluc,
  output logic [1:0]        pcsource,
  output logic [CNT_W-1:0]  instret,
  output logic              timeout,
  output logic              trap
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t                   state, nxt;
  logic [OP_W-1:0]          op_q, dec_op;
  logic [FUNC_W-1:0]        func_q, dec_func;
  logic [$bits(ctrl_t)-1:0] ctl_bits;
  ctrl_t                    ctl;
  logic [WAIT_W-1:0]        wait_cnt;
  logic                     waiting, abort, retire;

  // IR is loaded on the edge into DECODE, so the live op is only trustworthy there; later states use the copy.
  assign dec_op   = (state == ST_DECODE) ? op : op_q;
  assign dec_func = (state == ST_DECODE) ? func : func_q;

  mc_ctrl_decode #(.OP_W(OP_W), .FUNC_W(FUNC_W)) u_decode (
    .op   (dec_op),
    .func (dec_func),
    .ctl  (ctl_bits)
  );

  assign ctl     = ctrl_t'(ctl_bits);
  assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
  assign abort   = waiting && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    nxt      = state;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    sext     = 1'b0;
    regrt    = 1'b0;
    jal      = 1'b0;
    wreg     = 1'b0;
    alium    = 1'b0;
    shift    = 1'b0;
    m2reg    = 1'b0;
    aluc     = '0;
    pcsource = PC_INC;
    case (state)
      ST_START: nxt = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          nxt     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (ctl.illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          nxt = ST_TRAP;
`else
          nxt = ST_FETCH;
`endif
        end else if (ctl.is_j) begin
          pcwrite  = 1'b1;
          pcsource = PC_JMP;
          wreg     = ctl.is_jal;
          jal      = ctl.is_jal;
          retire   = 1'b1;
          nxt      = ST_FETCH;
        end else if (ctl.is_jr) begin
          pcwrite  = 1'b1;
          pcsource = PC_REG;
          retire   = 1'b1;
          nxt      = ST_FETCH;
        end else begin
          nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctl.is_br) begin
          pcwrite  = ctl.is_bne ? !z : z;
          pcsource = PC_BR;
          retire   = 1'b1;
          nxt      = ST_FETCH;
        end else if (ctl.is_lw || ctl.is_sw) begin
          nxt = ST_MEM;
        end else begin
          nxt = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = ctl.is_sw;
        if (mem_ready) begin
          retire = ctl.is_sw;
          nxt    = ctl.is_sw ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        wreg   = 1'b1;
        m2reg  = ctl.is_lw;
        retire = 1'b1;
        nxt    = ST_FETCH;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: nxt = ST_TRAP;
`endif
      default: nxt = ST_START;
    endcase
    if (abort) nxt = ST_FETCH;
    if ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB)) begin
      sext  = ctl.sext;
      regrt = ctl.regrt;
      alium = ctl.alium;
      shift = ctl.shift;
      aluc  = ALUC_W'(ctl.aluc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_START;
      op_q     <= '0;
      func_q   <= '0;
      wait_cnt <= '0;
      instret  <= '0;
      timeout  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_DECODE) begin
        op_q   <= op;
        func_q <= func;
      end
      wait_cnt <= (waiting && !abort) ? wait_cnt + WAIT_W'(1) : '0;
      if (retire) instret <= instret + CNT_W'(1);
      if (abort) timeout <= 1'b1;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              trap <= 1'b0;
    else if (nxt == ST_TRAP) trap <= 1'b1;
  end
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors are queued per instruction, then popped and compared.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  func = '0;
  logic        z = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, pcwrite, irwrite, sext, regrt, jal, wreg, alium, shift, m2reg;
  logic [3:0]  aluc;
  logic [1:0]  pcsource;
  logic [31:0] instret;
  logic        timeout, trap;

  typedef struct packed {
    logic mem_req, mem_we, pcwrite, irwrite, sext, regrt, jal, wreg, alium, shift, m2reg;
    logic [3:0] aluc;
    logic [1:0] pcsource;
  } vec_t;

  typedef struct packed {
    logic rdy;
    vec_t v;
  } cyc_t;

  cyc_t        sb_q[$];
  vec_t        act;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_instret = '0;

  always #5 clk = ~clk;

  assign act = {mem_req, mem_we, pcwrite, irwrite, sext, regrt, jal, wreg, alium, shift, m2reg, aluc, pcsource};

  mc_ctrl #(.OP_W(6), .FUNC_W(6), .ALUC_W(4), .CNT_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .pcwrite(pcwrite), .irwrite(irwrite),
    .sext(sext), .regrt(regrt), .jal(jal), .wreg(wreg), .alium(alium), .shift(shift),
    .m2reg(m2reg), .aluc(aluc), .pcsource(pcsource), .instret(instret),
    .timeout(timeout), .trap(trap)
  );

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08};
    return o inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
  endfunction

  // Expected EXEC/MEM/WB static controls from the ISA table.
  function automatic vec_t stat(input logic [5:0] o, input logic [5:0] f);
    vec_t v;
    v = '0;
    case (o)
      6'h00: case (f)
        6'h22: v.aluc = 4'd1;
        6'h24: v.aluc = 4'd2;
        6'h25: v.aluc = 4'd3;
        6'h26: v.aluc = 4'd4;
        6'h00: begin v.aluc = 4'd6; v.shift = 1'b1; end
        6'h02: begin v.aluc = 4'd7; v.shift = 1'b1; end
        6'h03: begin v.aluc = 4'd8; v.shift = 1'b1; end
        default: v.aluc = 4'd0;
      endcase
      6'h08: begin v.sext = 1'b1; v.regrt = 1'b1; v.alium = 1'b1; end
      6'h0c: begin v.regrt = 1'b1; v.alium = 1'b1; v.aluc = 4'd2; end
      6'h0d: begin v.regrt = 1'b1; v.alium = 1'b1; v.aluc = 4'd3; end
      6'h0e: begin v.regrt = 1'b1; v.alium = 1'b1; v.aluc = 4'd4; end
      6'h0f: begin v.regrt = 1'b1; v.alium = 1'b1; v.aluc = 4'd5; end
      6'h23: begin v.sext = 1'b1; v.regrt = 1'b1; v.alium = 1'b1; end
      6'h2b: begin v.sext = 1'b1; v.alium = 1'b1; end
      6'h04, 6'h05: begin v.sext = 1'b1; v.aluc = 4'd1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic push(input logic rdy, input vec_t v);
    cyc_t c;
    c.rdy = rdy;
    c.v   = v;
    sb_q.push_back(c);
  endtask

  task automatic push_fetch(input int fw);
    vec_t v;
    v = '0;
    v.mem_req = 1'b1;
    for (int i = 0; i < fw; i++) push(1'b0, v);
    v.irwrite = 1'b1;
    v.pcwrite = 1'b1;
    push(1'b1, v);
  endtask

  task automatic drain(input string name);
    cyc_t c;
    int   n;
    n = 0;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      @(negedge clk);
      mem_ready = c.rdy;
      #1;
      tests++;
      if (act !== c.v) begin
        fails++;
        $display("FAIL %s cycle %0d: controls got %h expected %h", name, n, act, c.v);
      end
      n++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (instret !== exp_instret) begin
      fails++;
      $display("FAIL %s instret: got %0d expected %0d", name, instret, exp_instret);
    end
  endtask

  // Queue the full expected cycle sequence of one instruction, then run it.
  task automatic issue(input string name, input logic [5:0] o, input logic [5:0] f, input logic zz,
                       input int fw, input int mw, input bit rdy_all);
    vec_t s, v;
    bit   ok, is_j, is_jr, is_br, is_lw, is_sw;
    ok    = legal(o, f);
    is_j  = (o == 6'h02) || (o == 6'h03);
    is_jr = (o == 6'h00) && (f == 6'h08);
    is_br = (o == 6'h04) || (o == 6'h05);
    is_lw = (o == 6'h23);
    is_sw = (o == 6'h2b);
    s     = stat(o, f);
    op = o; func = f; z = zz;
    push_fetch(fw);
    v = '0;
    if (ok && is_j) begin
      v.pcwrite = 1'b1; v.pcsource = 2'b10;
      if (o == 6'h03) begin v.wreg = 1'b1; v.jal = 1'b1; end
    end else if (ok && is_jr) begin
      v.pcwrite = 1'b1; v.pcsource = 2'b11;
    end
    push(rdy_all ? 1'b1 : 1'($urandom_range(0, 1)), v);
    if (ok && !is_j && !is_jr) begin
      v = s;
      if (is_br) begin
        v.pcwrite  = (o == 6'h04) ? zz : !zz;
        v.pcsource = 2'b01;
      end
      push(rdy_all ? 1'b1 : 1'($urandom_range(0, 1)), v);
      if (is_lw || is_sw) begin
        v = s; v.mem_req = 1'b1; v.mem_we = is_sw;
        for (int i = 0; i < mw; i++) push(1'b0, v);
        push(1'b1, v);
      end
      if (!is_sw && !is_br) begin
        v = s; v.wreg = 1'b1; v.m2reg = is_lw;
        push(rdy_all ? 1'b1 : 1'($urandom_range(0, 1)), v);
      end
    end
    if (ok) exp_instret++;
    drain(name);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (act !== '0 || instret !== 32'd0 || timeout !== 1'b0 || trap !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got ctl=%h instret=%0d timeout=%b trap=%b expected all 0", act, instret, timeout, trap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (act !== '0) begin
      fails++;
      $display("FAIL start_state: got %h expected 0", act);
    end
    exp_instret = '0;
  endtask

  task automatic test_add;
    issue("add", 6'h00, 6'h20, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_lw_wait;
    issue("lw_wait3", 6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
  endtask

  task automatic test_branch;
    issue("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
    issue("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
    issue("bne_z0", 6'h05, 6'h00, 1'b0, 1, 0, 1'b0);
    issue("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_jumps;
    issue("j",   6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
    issue("jal", 6'h03, 6'h00, 1'b0, 2, 0, 1'b0);
    issue("jr",  6'h00, 6'h08, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_alu_mix;
    logic [11:0] tbl [12];
    logic [11:0] e;
    tbl = '{{6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h26},
            {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03}, {6'h08, 6'h00},
            {6'h0c, 6'h00}, {6'h0d, 6'h00}, {6'h0e, 6'h00}, {6'h0f, 6'h00}};
    for (int i = 0; i < 12; i++) begin
      e = tbl[i];
      issue($sformatf("alu_%0d", i), e[11:6], e[5:0], 1'b0, i % 2, 0, 1'b0);
    end
    issue("sw_wait", 6'h2b, 6'h00, 1'b0, 2, 1, 1'b0);
    issue("sw_fast", 6'h2b, 6'h00, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_illegal;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    vec_t v;
    v = '0;
    op = 6'h3f; func = 6'h00;
    push_fetch(0);
    for (int i = 0; i < 4; i++) push(1'b1, v);
    drain("illegal_trap");
    tests++;
    if (trap !== 1'b1) begin
      fails++;
      $display("FAIL illegal_trap flag: got %b expected 1", trap);
    end
`else
    issue("illegal_op", 6'h3f, 6'h00, 1'b0, 0, 0, 1'b0);
    issue("illegal_func", 6'h00, 6'h01, 1'b0, 0, 0, 1'b0);
    tests++;
    if (trap !== 1'b0) begin
      fails++;
      $display("FAIL illegal_notrap flag: got %b expected 0", trap);
    end
    issue("after_illegal", 6'h00, 6'h20, 1'b0, 0, 0, 1'b1);
`endif
  endtask

  task automatic test_timeout;
    vec_t v;
    tests++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got %b expected 0", timeout);
    end
    op = 6'h00; func = 6'h20;
    v = '0; v.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, v);
    drain("fetch_timeout");
    tests++;
    if (timeout !== 1'b1) begin
      fails++;
      $display("FAIL fetch_timeout flag: got %b expected 1", timeout);
    end
    op = 6'h23; func = 6'h00;
    push_fetch(0);
    push(1'b0, '0);
    push(1'b1, stat(6'h23, 6'h00));
    v = stat(6'h23, 6'h00); v.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, v);
    drain("mem_timeout");
    issue("after_timeout", 6'h00, 6'h20, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_mem;
    vec_t v;
    op = 6'h23; func = 6'h00;
    push_fetch(0);
    push(1'b0, '0);
    push(1'b0, stat(6'h23, 6'h00));
    v = stat(6'h23, 6'h00); v.mem_req = 1'b1;
    push(1'b0, v);
    drain("pre_reset_lw");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (act !== '0 || instret !== 32'd0 || timeout !== 1'b0 || trap !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_mem: got ctl=%h instret=%0d timeout=%b trap=%b expected all 0", act, instret, timeout, trap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    tests++;
    if (act !== '0) begin
      fails++;
      $display("FAIL reset_release_start: got %h expected 0", act);
    end
    @(negedge clk);
    #1;
    v = '0; v.mem_req = 1'b1;
    tests++;
    if (act !== v) begin
      fails++;
      $display("FAIL reset_release_fetch: got %h expected %h", act, v);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_alu_mix();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
